// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared types, mode constants and chunk sizing for pipe_adder
package pipe_adder_pkg;

  // Operation select carried on sub_in
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Width of one carry chunk; WIDTH must be a multiple of STAGES
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Control part of the per-stage payload; operand skew and sum deskew
  // registers are sized per stage inside pipe_adder
  typedef struct packed {
    logic valid;
`ifdef PIPE_ADDER_SAT_EN
    logic sat;
`endif
    logic carry;
  } stage_ctrl_t;

endpackage

// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operand/result handshake bundle for pipe_adder (sat_in under PIPE_ADDER_SAT_EN)
interface pipe_adder_if #(
  parameter int WIDTH = 16
);

  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             sub_in;
  logic             carry_in;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             ovf_out;
`ifdef PIPE_ADDER_SAT_EN
  logic             sat_in;
`endif

`ifdef PIPE_ADDER_SAT_EN
  modport master (
    output valid_in, a_in, b_in, sub_in, carry_in, sat_in, ready_in,
    input  ready_out, valid_out, sum_out, carry_out, ovf_out
  );
  modport slave (
    input  valid_in, a_in, b_in, sub_in, carry_in, sat_in, ready_in,
    output ready_out, valid_out, sum_out, carry_out, ovf_out
  );
`else
  modport master (
    output valid_in, a_in, b_in, sub_in, carry_in, ready_in,
    input  ready_out, valid_out, sum_out, carry_out, ovf_out
  );
  modport slave (
    input  valid_in, a_in, b_in, sub_in, carry_in, ready_in,
    output ready_out, valid_out, sum_out, carry_out, ovf_out
  );
`endif

endinterface

// File: rtl/pipe_adder_chunk.sv
// rtl/pipe_adder_chunk.sv - combinational CHUNK-bit ripple adder built from half-adder pairs
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  // Each bit is a full adder made of two half adders; carry ripples LSB to MSB
  always_comb begin
    logic c;
    logic p;
    logic g;
    logic h;
    c = cin;
    sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      p = a[i] ^ b[i];
      g = a[i] & b[i];
      sum[i] = p ^ c;
      h = p & c;
      c = g | h;
    end
    cout = c;
  end

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined add/subtract, one carry chunk per clock (PIPE_ADDER_SAT_EN adds saturation)
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic        clk_in,
  input logic        rst_n_in,
  pipe_adder_if.slave bus
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  logic advance;

  // One global stall: the whole pipe moves unless a result is waiting
  assign advance       = bus.ready_in | ~bus.valid_out;
  assign bus.ready_out = advance;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = k * CHUNK;
    localparam int HI = LO + CHUNK;

    logic [WIDTH-1:LO] a_src;
    logic [WIDTH-1:LO] b_src;
    stage_ctrl_t       ctrl_src;
    stage_ctrl_t       ctrl_d;
    stage_ctrl_t       ctrl_q;
    logic [CHUNK-1:0]  chunk_sum;
    logic              chunk_carry;
    logic [HI-1:0]     sum_d;
    logic [HI-1:0]     sum_q;

    if (k == 0) begin : head
      // B is inverted here once; later stages only ever see B'
      assign a_src = bus.a_in;
      assign b_src = bus.b_in ^ {WIDTH{bus.sub_in == SUB}};
      assign sum_d = chunk_sum;

      // Beat control entering the pipe; subtract forces carry-in to 1
      always_comb begin
        ctrl_src       = '0;
        ctrl_src.valid = bus.valid_in;
        ctrl_src.carry = (bus.sub_in == ADD) ? bus.carry_in : 1'b1;
`ifdef PIPE_ADDER_SAT_EN
        ctrl_src.sat   = bus.sat_in;
`endif
      end
    end else begin : body
      assign a_src    = stg[k-1].skew.a_q;
      assign b_src    = stg[k-1].skew.b_q;
      assign ctrl_src = stg[k-1].ctrl_q;
      assign sum_d    = {chunk_sum, stg[k-1].sum_q};
    end

    adder_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .a   (a_src[LO +: CHUNK]),
      .b   (b_src[LO +: CHUNK]),
      .cin (ctrl_src.carry),
      .sum (chunk_sum),
      .cout(chunk_carry)
    );

    // Pass control along, replacing the carry with this chunk's carry-out
    always_comb begin
      ctrl_d       = ctrl_src;
      ctrl_d.carry = chunk_carry;
    end

    // Control and growing deskewed sum register for this stage
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        ctrl_q <= '0;
        sum_q  <= '0;
      end else if (advance) begin
        ctrl_q <= ctrl_d;
        sum_q  <= sum_d;
      end
    end

    if (k < LAST) begin : skew
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;

      // Operand chunks not yet added ride along to later stages
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_src[WIDTH-1:HI];
          b_q <= b_src[WIDTH-1:HI];
        end
      end
    end else begin : fin
      logic ovf_d;
      logic ovf_q;

      assign ovf_d = (a_src[WIDTH-1] == b_src[WIDTH-1]) &&
                     (chunk_sum[CHUNK-1] != a_src[WIDTH-1]);

      // Signed overflow captured alongside the final sum
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign bus.valid_out = stg[LAST].ctrl_q.valid;
  assign bus.carry_out = stg[LAST].ctrl_q.carry;
  assign bus.ovf_out   = stg[LAST].fin.ovf_q;

`ifdef PIPE_ADDER_SAT_EN
  // On overflow the wrapped sign is the opposite of the true sign, so clamp
  // toward the side the wrapped MSB is not on
  assign bus.sum_out = (stg[LAST].ctrl_q.sat && stg[LAST].fin.ovf_q) ?
                       (stg[LAST].sum_q[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                                 : {1'b1, {(WIDTH-1){1'b0}}}) :
                       stg[LAST].sum_q;
`else
  assign bus.sum_out = stg[LAST].sum_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder (16/4 and 8/1 configurations)
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  localparam int W      = 16;
  localparam int S      = 4;
  localparam int W1     = 8;
  localparam int NBEATS = 32;
  localparam int N1     = 20;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic        sat;
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(W))  bus  ();
  pipe_adder_if #(.WIDTH(W1)) bus1 ();

  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  pipe_adder #(.WIDTH(W1), .STAGES(1)) dut1 (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus1)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int w, input logic [15:0] sum, input logic c, input logic o);
    return (64'(o) << (w + 1)) | (64'(c) << w) | 64'(sum);
  endfunction

  function automatic logic [63:0] out16();
    return pk(W, bus.sum_out, bus.carry_out, bus.ovf_out) | (64'(bus.valid_out) << 20);
  endfunction

  function automatic logic [63:0] out8();
    return pk(W1, 16'(bus1.sum_out), bus1.carry_out, bus1.ovf_out) | (64'(bus1.valid_out) << 20);
  endfunction

  // Reference: plain integer arithmetic on w-bit two's-complement values
  function automatic void ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                    input logic sub, input logic cin, input logic sat,
                                    output logic [15:0] sum, output logic carry, output logic ovf);
    longint unsigned mask, bb, full, s;
    bit sa, sb, ss;
    mask = (64'd1 << w) - 1;
    bb = longint'(b) & mask;
    if (sub) bb = ~bb & mask;
    full = (longint'(a) & mask) + bb + longint'(sub ? 1'b1 : cin);
    s = full & mask;
    carry = 1'((full >> w) & 1);
    sa = 1'((longint'(a) >> (w - 1)) & 1);
    sb = 1'((bb >> (w - 1)) & 1);
    ss = 1'((s >> (w - 1)) & 1);
    ovf = (sa == sb) && (ss != sa);
    if (sat && ovf) s = sa ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 1);
    sum = 16'(s);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1);
  end

  initial begin : main
    vec_t        vecs[$];
    vec_t        v1[$];
    vec_t        v;
    bit          early;
    bit          late;
    int          sent;
    int          cyc;
    bit          acc;
    bit          prev_stall;
    logic [63:0] prev_out;
    logic [63:0] exp_q[$];
    logic [15:0] ms;
    logic        mc;
    logic        mo;
    logic        sv;

    vecs.push_back('{16'hFFFF, 16'h0001, ADD, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h0005, 16'h0007, SUB, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, SUB, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, ADD, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h1234, 16'h1111, ADD, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0});
    vecs.push_back('{16'h0010, 16'h0001, SUB, 1'b0, 1'b0, 16'h000F, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, ADD, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
`ifdef PIPE_ADDER_SAT_EN
    vecs.push_back('{16'h7FFF, 16'h0001, ADD, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1});
    vecs.push_back('{16'h8000, 16'h0001, SUB, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1});
    vecs.push_back('{16'h0001, 16'h0001, ADD, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0});
`endif

    v1.push_back('{16'h0080, 16'h0080, ADD, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    v1.push_back('{16'h007F, 16'h0001, ADD, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1});
    v1.push_back('{16'h0005, 16'h0007, SUB, 1'b1, 1'b0, 16'h00FE, 1'b0, 1'b0});

    bus.valid_in = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.sub_in = 1'b0;
    bus.carry_in = 1'b0; bus.ready_in = 1'b1;
    bus1.valid_in = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.sub_in = 1'b0;
    bus1.carry_in = 1'b0; bus1.ready_in = 1'b1;
`ifdef PIPE_ADDER_SAT_EN
    bus.sat_in = 1'b0;
    bus1.sat_in = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("reset_out16", {bus.valid_out, bus.ready_out, bus.carry_out, bus.ovf_out, bus.sum_out},
          {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
    check("reset_out8", {bus1.valid_out, bus1.ready_out, bus1.carry_out, bus1.ovf_out, bus1.sum_out},
          {1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    rst_n = 1'b1;

    // Directed vectors: one beat at a time, latency must be exactly S
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      bus.a_in = v.a; bus.b_in = v.b; bus.sub_in = v.sub; bus.carry_in = v.cin;
`ifdef PIPE_ADDER_SAT_EN
      bus.sat_in = v.sat;
`endif
      bus.valid_in = 1'b1;
      bus.ready_in = 1'b1;
      early = 1'b0;
      for (int c = 1; c <= S; c++) begin
        @(negedge clk);
        if (c == 1) bus.valid_in = 1'b0;
        if (c < S) early |= bus.valid_out;
      end
      check($sformatf("vec%0d_latency", i), {early, bus.valid_out}, 2'b01);
      check($sformatf("vec%0d_result", i), pk(W, bus.sum_out, bus.carry_out, bus.ovf_out),
            pk(W, v.sum, v.carry, v.ovf));
    end

    // Random stream with pseudo-random backpressure against the model
    sent = 0; cyc = 0; acc = 1'b0; prev_stall = 1'b0; prev_out = '0;
    while ((sent < NBEATS || exp_q.size() != 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) check("stall_hold", out16(), prev_out);
      if (acc) bus.valid_in = 1'b0;
      if (!bus.valid_in && sent < NBEATS && $urandom_range(0, 3) != 0) begin
        bus.a_in = 16'($urandom);
        bus.b_in = 16'($urandom);
        bus.sub_in = 1'($urandom);
        bus.carry_in = 1'($urandom);
`ifdef PIPE_ADDER_SAT_EN
        bus.sat_in = 1'($urandom);
`endif
        bus.valid_in = 1'b1;
      end
      bus.ready_in = ($urandom_range(0, 2) != 0);
      #1;
      if (bus.valid_out && bus.ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: got beat %0h expected none", out16());
        end else begin
          check("stream_beat", out16(), exp_q.pop_front());
        end
      end
      acc = bus.valid_in && bus.ready_out;
      if (acc) begin
        sv = 1'b0;
`ifdef PIPE_ADDER_SAT_EN
        sv = bus.sat_in;
`endif
        ref_model(W, bus.a_in, bus.b_in, bus.sub_in, bus.carry_in, sv, ms, mc, mo);
        exp_q.push_back(pk(W, ms, mc, mo) | (64'd1 << 20));
        sent++;
      end
      prev_stall = bus.valid_out && !bus.ready_in;
      prev_out = out16();
    end
    check("stream_done", {sent == NBEATS, exp_q.size() == 0}, 2'b11);
    bus.valid_in = 1'b0;
`ifdef PIPE_ADDER_SAT_EN
    bus.sat_in = 1'b0;
`endif

    // Mid-flight reset: three beats in, first one held at the output
    @(negedge clk);
    bus.ready_in = 1'b1;
    repeat (S + 1) @(negedge clk);
    bus.ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.a_in = 16'(16'h1000 + i); bus.b_in = 16'h0101;
      bus.sub_in = 1'b0; bus.carry_in = 1'b0; bus.valid_in = 1'b1;
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre", out16(), pk(W, 16'h1101, 1'b0, 1'b0) | (64'd1 << 20));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", {bus.valid_out, bus.sum_out}, {1'b0, 16'h0000});
    @(negedge clk);
    rst_n = 1'b1;
    bus.ready_in = 1'b1;
    late = 1'b0;
    repeat (8) begin
      @(negedge clk);
      late |= bus.valid_out;
    end
    check("rst_no_ghost", late, 1'b0);

    // STAGES=1, WIDTH=8: directed then random, back-to-back with latency 1
    for (int i = 0; i < N1; i++) begin
      v.a = 16'($urandom_range(0, 255));
      v.b = 16'($urandom_range(0, 255));
      v.sub = 1'($urandom);
      v.cin = 1'($urandom);
      v.sat = 1'b0;
      ref_model(W1, v.a, v.b, v.sub, v.cin, 1'b0, v.sum, v.carry, v.ovf);
      v1.push_back(v);
    end
    for (int i = 0; i <= v1.size(); i++) begin
      @(negedge clk);
      if (i > 0)
        check($sformatf("s1_beat%0d", i - 1), out8(),
              pk(W1, v1[i-1].sum, v1[i-1].carry, v1[i-1].ovf) | (64'd1 << 20));
      if (i < v1.size()) begin
        bus1.a_in = v1[i].a[7:0]; bus1.b_in = v1[i].b[7:0];
        bus1.sub_in = v1[i].sub; bus1.carry_in = v1[i].cin;
        bus1.valid_in = 1'b1;
      end else begin
        bus1.valid_in = 1'b0;
      end
    end
    @(negedge clk);
    check("s1_drain", bus1.valid_out, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
